// File: rtl/quad_decoder_counter.sv
// Quadrature encoder receiver: sync, glitch filter, A/B decode, up/down position count.
// Latency: an input level change reaches count/step on the (FILT+3)th clock edge.
module quad_decoder_counter #(
  parameter int WIDTH = 8,
  parameter int FILT  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             quad_i,
  input  logic             idx_en,
  input  logic             err_clr,
  output logic [WIDTH-1:0] count,
  output logic             up_down,
  output logic             step,
  output logic             err
);

  localparam int FCW = (FILT < 2) ? 1 : $clog2(FILT + 1);
  localparam int PCW = $clog2(FILT + 3);
  localparam logic [PCW-1:0] PRIME_LOAD = PCW'(FILT + 2);
  localparam logic [FCW-1:0] FILT_LAST  = FCW'(FILT - 1);

  // Bit order in all three-wide vectors: [2] = a, [1] = b, [0] = index
  logic [2:0]          sync1, sync2, filt;
  logic [2:0][FCW-1:0] fcnt;
  logic [PCW-1:0]      prime_cnt;
  logic                priming;

  logic [1:0] prev_ab;
  logic       prev_i;
  logic [1:0] cur_pos, prev_pos, delta;
  logic       fwd, rev, bad, idx_rise;

  assign priming = (prime_cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      filt      <= '0;
      fcnt      <= '0;
      prime_cnt <= PRIME_LOAD;
    end else begin
      sync1 <= {quad_a, quad_b, quad_i};
      sync2 <= sync1;
      if (priming) begin
        // Track the pins directly so a resting encoder never looks like a transition
        prime_cnt <= prime_cnt - PCW'(1);
        filt      <= sync2;
        fcnt      <= '0;
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (sync2[k] == filt[k]) begin
            fcnt[k] <= '0;
          end else if (fcnt[k] == FILT_LAST) begin
            filt[k] <= sync2[k];
            fcnt[k] <= '0;
          end else begin
            fcnt[k] <= fcnt[k] + FCW'(1);
          end
        end
      end
    end
  end

  // Map Gray-coded phase 00,10,11,01 to positions 0..3 so the step is a mod-4 difference
  assign cur_pos  = {filt[1], filt[2] ^ filt[1]};
  assign prev_pos = {prev_ab[0], prev_ab[1] ^ prev_ab[0]};
  assign delta    = cur_pos - prev_pos;

  assign fwd      = !priming && (delta == 2'd1);
  assign rev      = !priming && (delta == 2'd3);
  assign bad      = !priming && (delta == 2'd2);
  assign idx_rise = !priming && idx_en && filt[0] && !prev_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      up_down <= 1'b0;
      step    <= 1'b0;
      err     <= 1'b0;
      prev_ab <= 2'b00;
      prev_i  <= 1'b0;
    end else begin
      if (priming) begin
        prev_ab <= sync2[2:1];
        prev_i  <= sync2[0];
        step    <= 1'b0;
      end else begin
        prev_ab <= filt[2:1];
        prev_i  <= filt[0];
        step    <= fwd | rev;
        if (fwd) up_down <= 1'b1;
        if (rev) up_down <= 1'b0;
        if (idx_rise)  count <= '0;
        else if (fwd)  count <= count + WIDTH'(1);
        else if (rev)  count <= count - WIDTH'(1);
      end
      // A fresh error outranks a simultaneous clear
      if (err_clr) err <= 1'b0;
      if (bad)     err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_quad_decoder_counter.sv
// Directed bench for quad_decoder_counter (WIDTH=8, FILT=2): table rows plus hand sequences.
module tb_quad_decoder_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       quad_a = 1'b0, quad_b = 1'b0, quad_i = 1'b0;
  logic       idx_en = 1'b0, err_clr = 1'b0;
  logic [7:0] count;
  logic       up_down, step, err;

  int checks = 0;
  int failures = 0;
  int steps;
  int first_edge;

  quad_decoder_counter #(.WIDTH(8), .FILT(2)) dut (
    .clk(clk), .reset(reset), .quad_a(quad_a), .quad_b(quad_b), .quad_i(quad_i),
    .idx_en(idx_en), .err_clr(err_clr), .count(count), .up_down(up_down),
    .step(step), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] ab;
    logic       clr;
    int         cyc;
    int         cnt;
    logic       ud;
    logic       er;
    int         st;
  } vec_t;

  vec_t       tbl [17];
  logic [1:0] fseq [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance n edges, sampling 1 time unit after each; count step pulses
  task automatic hold(input int n);
    steps = 0;
    first_edge = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (step === 1'b1) begin
        steps++;
        if (first_edge == 0) first_edge = k;
      end
    end
  endtask

  task automatic move(input logic [1:0] ab, input int n);
    quad_a = ab[1];
    quad_b = ab[0];
    hold(n);
  endtask

  task automatic do_reset(input logic [1:0] ab);
    reset = 1'b1;
    quad_a = ab[1];
    quad_b = ab[0];
    hold(3);
    reset = 1'b0;
    hold(8);
  endtask

  initial begin
    fseq[0] = 2'b10; fseq[1] = 2'b11; fseq[2] = 2'b01; fseq[3] = 2'b00;

    //            rst   ab     clr  cyc cnt ud    err   steps
    tbl[0]  = '{1'b1, 2'b11, 1'b0, 3,  0,   1'b0, 1'b0, 0};
    tbl[1]  = '{1'b0, 2'b11, 1'b0, 10, 0,   1'b0, 1'b0, 0};
    tbl[2]  = '{1'b1, 2'b00, 1'b0, 3,  0,   1'b0, 1'b0, 0};
    tbl[3]  = '{1'b0, 2'b00, 1'b0, 8,  0,   1'b0, 1'b0, 0};
    tbl[4]  = '{1'b0, 2'b10, 1'b0, 8,  1,   1'b1, 1'b0, 1};
    tbl[5]  = '{1'b0, 2'b11, 1'b0, 8,  2,   1'b1, 1'b0, 1};
    tbl[6]  = '{1'b0, 2'b01, 1'b0, 8,  3,   1'b1, 1'b0, 1};
    tbl[7]  = '{1'b0, 2'b00, 1'b0, 8,  4,   1'b1, 1'b0, 1};
    tbl[8]  = '{1'b1, 2'b00, 1'b0, 3,  0,   1'b0, 1'b0, 0};
    tbl[9]  = '{1'b0, 2'b00, 1'b0, 8,  0,   1'b0, 1'b0, 0};
    tbl[10] = '{1'b0, 2'b01, 1'b0, 8,  255, 1'b0, 1'b0, 1};
    tbl[11] = '{1'b0, 2'b00, 1'b0, 8,  0,   1'b1, 1'b0, 1};
    tbl[12] = '{1'b0, 2'b01, 1'b0, 8,  255, 1'b0, 1'b0, 1};
    tbl[13] = '{1'b0, 2'b00, 1'b0, 8,  0,   1'b1, 1'b0, 1};
    tbl[14] = '{1'b0, 2'b11, 1'b0, 8,  0,   1'b1, 1'b1, 0};
    tbl[15] = '{1'b0, 2'b11, 1'b1, 2,  0,   1'b1, 1'b0, 0};
    tbl[16] = '{1'b0, 2'b11, 1'b0, 4,  0,   1'b1, 1'b0, 0};

    @(posedge clk);
    #1;

    for (int r = 0; r < 17; r++) begin
      reset   = tbl[r].rst;
      err_clr = tbl[r].clr;
      move(tbl[r].ab, tbl[r].cyc);
      check($sformatf("row%0d count", r), 32'(count), 32'(tbl[r].cnt));
      check($sformatf("row%0d up_down", r), 32'(up_down), 32'(tbl[r].ud));
      check($sformatf("row%0d err", r), 32'(err), 32'(tbl[r].er));
      check($sformatf("row%0d steps", r), 32'(steps), 32'(tbl[r].st));
    end
    reset   = 1'b0;
    err_clr = 1'b0;

    // Latency: step must appear on the 5th edge after the input change
    move(2'b01, 8);
    check("lat fwd edge", 32'(first_edge), 32'd5);
    check("lat fwd count", 32'(count), 32'd1);
    check("lat fwd up_down", 32'(up_down), 32'd1);
    move(2'b11, 8);
    check("lat rev edge", 32'(first_edge), 32'd5);
    check("lat rev count", 32'(count), 32'd0);
    check("lat rev up_down", 32'(up_down), 32'd0);

    // One-cycle glitch on A in state 00
    do_reset(2'b00);
    quad_a = 1'b1;
    hold(1);
    quad_a = 1'b0;
    hold(8);
    check("glitch steps", 32'(steps), 32'd0);
    check("glitch count", 32'(count), 32'd0);
    check("glitch err", 32'(err), 32'd0);

    // Error set on the same edge as err_clr: set wins
    quad_a = 1'b1;
    quad_b = 1'b1;
    hold(4);
    check("coinc err pre", 32'(err), 32'd0);
    err_clr = 1'b1;
    hold(1);
    err_clr = 1'b0;
    check("coinc err", 32'(err), 32'd1);
    hold(4);
    check("coinc err sticky", 32'(err), 32'd1);
    check("coinc count", 32'(count), 32'd0);
    err_clr = 1'b1;
    hold(1);
    err_clr = 1'b0;
    check("coinc err cleared", 32'(err), 32'd0);

    // Index zeroing with idx_en = 1
    do_reset(2'b00);
    for (int k = 0; k < 37; k++) move(fseq[k % 4], 6);
    check("idx pre count", 32'(count), 32'd37);
    idx_en = 1'b1;
    quad_i = 1'b1;
    hold(4);
    quad_i = 1'b0;
    hold(8);
    check("idx zero count", 32'(count), 32'd0);
    check("idx zero steps", 32'(steps), 32'd0);

    // Same pulse with idx_en = 0 leaves the count alone
    for (int k = 37; k < 74; k++) move(fseq[k % 4], 6);
    check("idx off pre count", 32'(count), 32'd37);
    idx_en = 1'b0;
    quad_i = 1'b1;
    hold(4);
    quad_i = 1'b0;
    hold(8);
    check("idx off count", 32'(count), 32'd37);

    // Index rise coincident with a forward step: count zeroed, step still reported
    move(2'b10, 8);
    check("pre coinc count", 32'(count), 32'd36);
    check("pre coinc up_down", 32'(up_down), 32'd0);
    idx_en = 1'b1;
    quad_i = 1'b1;
    move(2'b11, 8);
    check("idx+step edge", 32'(first_edge), 32'd5);
    check("idx+step steps", 32'(steps), 32'd1);
    check("idx+step count", 32'(count), 32'd0);
    check("idx+step up_down", 32'(up_down), 32'd1);
    check("idx+step err", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
